// File: rtl/internal_memory_arbiter_if.sv
// Requester-side and memory-side buses of the internal memory arbiter.
// master = arbiter view, slave = requesters plus memory.
interface internal_memory_arbiter_if #(
  parameter int TagWidth = 21,
  parameter int Ports    = 4,
  parameter int PortBits = 2
);
  logic [Ports-1:0]                    RACT;
  logic [Ports-1:0]                    RCMD;
  logic [Ports-1:0][14:0]              RADDR;
  logic [Ports-1:0][7:0]               RBE;
  logic [Ports-1:0][63:0]              RDI;
  logic [Ports-1:0][TagWidth-1:0]      RTI;
  logic [Ports-1:0]                    RNEXT;
  logic [Ports-1:0]                    RDRDY;
  logic [63:0]                         RDO;
  logic [TagWidth-1:0]                 RTO;

  logic                                MACT;
  logic                                MCMD;
  logic [14:0]                         MADDR;
  logic [7:0]                          MBE;
  logic [63:0]                         MDI;
  logic [TagWidth+PortBits-1:0]        MTI;
  logic                                MDRDY;
  logic [63:0]                         MDO;
  logic [TagWidth+PortBits-1:0]        MTO;

  modport master (
    input  RACT, RCMD, RADDR, RBE, RDI, RTI, MDRDY, MDO, MTO,
    output RNEXT, RDRDY, RDO, RTO, MACT, MCMD, MADDR, MBE, MDI, MTI
  );

  modport slave (
    output RACT, RCMD, RADDR, RBE, RDI, RTI, MDRDY, MDO, MTO,
    input  RNEXT, RDRDY, RDO, RTO, MACT, MCMD, MADDR, MBE, MDI, MTI
  );
endinterface

// File: rtl/internal_memory_arbiter.sv
// Round-robin arbiter sharing one 64-bit internal memory port among up to four
// requesters; the port index rides in the upper tag bits to steer read data back.
module internal_memory_arbiter #(
  parameter int TagWidth = 21,
  parameter int Ports    = 4,
  parameter int PortBits = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  internal_memory_arbiter_if.master bus
);

  logic [PortBits-1:0] ptr;
  logic [PortBits-1:0] gnt;
  logic [PortBits-1:0] cand;
  logic                gnt_vld;
  logic                discard;

  // First requester found scanning upward from ptr, wrapping modulo Ports.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int i = 0; i < Ports; i++) begin
      cand = PortBits'((int'(ptr) + i) % Ports);
      if (!gnt_vld && bus.RACT[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign bus.RNEXT = (gnt_vld && !RESET) ? (Ports'(1) << gnt) : '0;

  always_ff @(posedge CLK) begin
    // Memory may still emit a response for a pre-reset read in the cycle after reset.
    discard <= RESET;
    if (RESET) begin
      ptr       <= '0;
      bus.MACT  <= 1'b0;
      bus.MCMD  <= 1'b0;
      bus.MADDR <= '0;
      bus.MBE   <= 8'hFF;
      bus.MDI   <= '0;
      bus.MTI   <= '0;
      bus.RDRDY <= '0;
      bus.RDO   <= '0;
      bus.RTO   <= '0;
    end else begin
      bus.MACT <= gnt_vld;
      if (gnt_vld) begin
        bus.MCMD  <= bus.RCMD[gnt];
        bus.MADDR <= bus.RADDR[gnt];
        bus.MBE   <= bus.RBE[gnt];
        bus.MDI   <= bus.RDI[gnt];
        bus.MTI   <= {gnt, bus.RTI[gnt]};
        ptr       <= (int'(gnt) == Ports - 1) ? '0 : gnt + 1'b1;
      end

      if (bus.MDRDY && !discard) begin
        // An index outside 0..Ports-1 matches no bit, so nothing is signalled.
        for (int i = 0; i < Ports; i++)
          bus.RDRDY[i] <= (bus.MTO[TagWidth +: PortBits] == PortBits'(i));
        bus.RDO <= bus.MDO;
        bus.RTO <= bus.MTO[TagWidth-1:0];
      end else begin
        bus.RDRDY <= '0;
      end
    end
  end

endmodule

// File: tb/tb_internal_memory_arbiter.sv
// Directed bench for internal_memory_arbiter with a 1-cycle byte-masked memory model.
module tb_internal_memory_arbiter;
  localparam int TW = 21;
  localparam int NP = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  internal_memory_arbiter_if #(.TagWidth(TW), .Ports(NP), .PortBits(2)) bus ();

  internal_memory_arbiter #(.TagWidth(TW), .Ports(NP), .PortBits(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: unwritten words read as a pattern derived from the address.
  function automatic logic [63:0] dflt(input logic [14:0] a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (!be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  logic [63:0] mem [32768];
  bit   [32767:0] wr;
  wire  [63:0] cur = wr[bus.MADDR] ? mem[bus.MADDR] : dflt(bus.MADDR);

  always @(posedge CLK) begin
    bus.MDRDY <= 1'b0;
    if (bus.MACT === 1'b1) begin
      if (bus.MCMD) begin
        bus.MDRDY <= 1'b1;
        bus.MDO   <= cur;
        bus.MTO   <= bus.MTI;
      end else begin
        mem[bus.MADDR] <= merge(cur, bus.MDI, bus.MBE);
        wr[bus.MADDR]  <= 1'b1;
      end
    end
  end

  task automatic req(input int p, input logic cmd, input logic [14:0] a,
                     input logic [7:0] be, input logic [63:0] d, input logic [TW-1:0] t);
    bus.RACT[p]  = 1'b1;
    bus.RCMD[p]  = cmd;
    bus.RADDR[p] = a;
    bus.RBE[p]   = be;
    bus.RDI[p]   = d;
    bus.RTI[p]   = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.RACT = '0; bus.RCMD = '0; bus.RADDR = '0; bus.RBE = '1; bus.RDI = '0; bus.RTI = '0;
    RESET = 1'b1;

    // Reset: RNEXT forced low even with every port requesting
    @(negedge CLK); bus.RACT = '1; #1;
    chk("rnext_in_reset", 64'(bus.RNEXT), 64'h0);
    @(negedge CLK); bus.RACT = '0; RESET = 1'b0; #1;
    chk("rst_mact",  64'(bus.MACT),  64'h0);
    chk("rst_mcmd",  64'(bus.MCMD),  64'h0);
    chk("rst_maddr", 64'(bus.MADDR), 64'h0);
    chk("rst_mbe",   64'(bus.MBE),   64'hFF);
    chk("rst_mdi",   bus.MDI,        64'h0);
    chk("rst_mti",   64'(bus.MTI),   64'h0);
    chk("rst_rdrdy", 64'(bus.RDRDY), 64'h0);
    chk("rst_rdo",   bus.RDO,        64'h0);
    chk("rst_rto",   64'(bus.RTO),   64'h0);

    // Single read on port 2
    @(negedge CLK); req(2, 1'b1, 15'h0010, 8'hFF, 64'h0, 21'h12345); #1;
    chk("sr_rnext", 64'(bus.RNEXT), 64'b0100);
    @(negedge CLK); bus.RACT = '0; #1;
    chk("sr_mact",  64'(bus.MACT),  64'h1);
    chk("sr_mcmd",  64'(bus.MCMD),  64'h1);
    chk("sr_maddr", 64'(bus.MADDR), 64'h10);
    chk("sr_mti",   64'(bus.MTI),   64'({2'd2, 21'h12345}));
    @(negedge CLK); #1;
    chk("sr_rdrdy_early", 64'(bus.RDRDY), 64'h0);
    @(negedge CLK); #1;
    chk("sr_rdrdy", 64'(bus.RDRDY), 64'b0100);
    chk("sr_rto",   64'(bus.RTO),   64'h12345);
    chk("sr_rdo",   bus.RDO,        64'hA5A5_0000_0000_0010);

    // Round robin from reset with all four ports requesting every cycle
    @(negedge CLK); RESET = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        RESET = 1'b0;
        for (int p = 0; p < NP; p++) req(p, 1'b1, 15'(p), 8'hFF, 64'h0, TW'(16 + p));
      end
      #1;
      chk("rr_rnext", 64'(bus.RNEXT), 64'(4'b0001 << (k % 4)));
      if (k >= 1) begin
        chk("rr_mact", 64'(bus.MACT), 64'h1);
        chk("rr_mti_port", 64'(bus.MTI[TW +: 2]), 64'((k - 1) % 4));
      end
      if (k >= 3) begin
        chk("rr_rdrdy", 64'(bus.RDRDY), 64'(4'b0001 << ((k - 3) % 4)));
        chk("rr_rto",   64'(bus.RTO),   64'(16 + (k - 3) % 4));
      end else begin
        chk("rr_rdrdy_early", 64'(bus.RDRDY), 64'h0);
      end
    end
    @(negedge CLK); bus.RACT = '0;
    repeat (4) @(negedge CLK);

    // Full write, byte write, then read of the same word
    @(negedge CLK); req(0, 1'b0, 15'd5, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, '0); #1;
    chk("bw_rnext0", 64'(bus.RNEXT), 64'b0001);
    @(negedge CLK); bus.RACT = '0; req(1, 1'b0, 15'd5, 8'hF0, 64'h1122_3344_5566_7788, '0); #1;
    chk("bw_rnext1", 64'(bus.RNEXT), 64'b0010);
    @(negedge CLK); bus.RACT = '0; req(0, 1'b1, 15'd5, 8'hFF, 64'h0, 21'h7); #1;
    chk("bw_rnext2", 64'(bus.RNEXT), 64'b0001);
    chk("bw_mbe",    64'(bus.MBE),   64'hF0);
    chk("bw_mdi",    bus.MDI,        64'h1122_3344_5566_7788);
    @(negedge CLK); bus.RACT = '0;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("bw_rdrdy", 64'(bus.RDRDY), 64'b0001);
    chk("bw_rdo",   bus.RDO,        64'hAAAA_BBBB_5566_7788);
    chk("bw_rto",   64'(bus.RTO),   64'h7);

    // Fairness skip: move ptr to 2, then only ports 1 and 3 request
    @(negedge CLK); req(1, 1'b0, 15'h100, 8'hFF, 64'h0, '0); #1;
    chk("fs_setup", 64'(bus.RNEXT), 64'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        bus.RACT = '0;
        req(1, 1'b0, 15'h101, 8'hFF, 64'h0, '0);
        req(3, 1'b0, 15'h103, 8'hFF, 64'h0, '0);
      end
      #1;
      chk("fs_rnext", 64'(bus.RNEXT), (k % 2 == 0) ? 64'b1000 : 64'b0010);
      if (k >= 1) chk("fs_mti_port", 64'(bus.MTI[TW +: 2]), (k % 2 == 1) ? 64'd3 : 64'd1);
    end
    @(negedge CLK); bus.RACT = '0;
    repeat (3) @(negedge CLK);

    // Reset one cycle after a read grant: the read is never signalled
    @(negedge CLK); req(2, 1'b1, 15'h0020, 8'hFF, 64'h0, 21'h0ABCD); #1;
    chk("rm_rnext", 64'(bus.RNEXT), 64'b0100);
    @(negedge CLK); bus.RACT = '1; RESET = 1'b1; #1;
    chk("rm_rnext_rst", 64'(bus.RNEXT), 64'h0);
    chk("rm_mact_issued", 64'(bus.MACT), 64'h1);
    @(negedge CLK); bus.RACT = '0; RESET = 1'b0; #1;
    chk("rm_mact",  64'(bus.MACT),  64'h0);
    chk("rm_maddr", 64'(bus.MADDR), 64'h0);
    chk("rm_mbe",   64'(bus.MBE),   64'hFF);
    chk("rm_mti",   64'(bus.MTI),   64'h0);
    chk("rm_rdo",   bus.RDO,        64'h0);
    chk("rm_rto",   64'(bus.RTO),   64'h0);
    chk("rm_rdrdy_t2", 64'(bus.RDRDY), 64'h0);
    @(negedge CLK); #1;
    chk("rm_rdrdy_t3", 64'(bus.RDRDY), 64'h0);
    chk("rm_rto_t3",   64'(bus.RTO),   64'h0);
    @(negedge CLK); #1;
    chk("rm_rdrdy_t4", 64'(bus.RDRDY), 64'h0);
    @(negedge CLK); req(1, 1'b1, 15'h0010, 8'hFF, 64'h0, 21'h55); #1;
    chk("rm_next_rnext", 64'(bus.RNEXT), 64'b0010);
    @(negedge CLK); bus.RACT = '0;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("rm_next_rdrdy", 64'(bus.RDRDY), 64'b0010);
    chk("rm_next_rdo",   bus.RDO,        64'hA5A5_0000_0000_0010);
    chk("rm_next_rto",   64'(bus.RTO),   64'h55);

    // Idle for 10 cycles; the pointer (at 2) must survive
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      chk("idle_mact",  64'(bus.MACT),  64'h0);
      chk("idle_rnext", 64'(bus.RNEXT), 64'h0);
      chk("idle_rdrdy", 64'(bus.RDRDY), 64'h0);
    end
    @(negedge CLK);
    for (int p = 0; p < NP; p++) req(p, 1'b0, 15'h200, 8'hFF, 64'h0, '0);
    #1;
    chk("idle_ptr_kept", 64'(bus.RNEXT), 64'b0100);
    @(negedge CLK); bus.RACT = '0;
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
